// File: rtl/uart_rx_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_pkg
// Shared types and constants for the UART RX framing controller:
//   state_e    - framing FSM states (hunt for sync, length, payload, checksum)
//   err_code_e - reason reported alongside a frame_err pulse
//   SYNC_DEFAULT, TIMER_W and a small helper that packs two payload bytes
//   into a little-endian 16-bit sample.
// -----------------------------------------------------------------------------
package uart_rx_frame_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CHK  = 2'd2,
    ERR_TMO  = 2'd3
  } err_code_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Width of the inter-byte idle counter.
  localparam int unsigned TIMER_W = 32;

  // Payload is little-endian: the older byte is the low half of the sample.
  function automatic logic [15:0] pack_sample(input logic [7:0] lo,
                                              input logic [7:0] hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl_if
// Valid/ready sample stream from the framing controller to the FFT loader.
//   sample       - 16-bit payload sample {byte1, byte0}
//   sample_valid - sample holds a valid sample
//   sample_ready - consumer accepts the sample this cycle
//   sample_first - qualifies sample: first sample of the frame
//   sample_last  - qualifies sample: last sample of the frame
// Modports: master = producer (controller), slave = consumer.
// -----------------------------------------------------------------------------
interface uart_rx_frame_ctrl_if;

  logic [15:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        sample_first;
  logic        sample_last;

  modport master (
    output sample,
    output sample_valid,
    output sample_first,
    output sample_last,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    input  sample_first,
    input  sample_last,
    output sample_ready
  );

endinterface

// File: rtl/uart_rx_frame_timer.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_timer
// Inter-byte idle counter for the framing controller. Only instantiated when
// UART_RX_FRAME_TIMEOUT_EN is defined.
// Ports:
//   clk     in  system clock
//   arstn   in  asynchronous active-low reset
//   clr     in  restart the idle count (a byte was popped, or controller idle)
//   run     in  count while a frame is in progress
//   expired out idle count has reached TIMEOUT_CYC-1 (combinational)
// The count restarts at the edge that consumes a byte, so expired rises
// TIMEOUT_CYC-1 edges later and the controller's registered error pulse
// appears exactly TIMEOUT_CYC edges after the last pop.
// -----------------------------------------------------------------------------
module uart_rx_frame_timer
  import uart_rx_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic arstn,
  input  logic clr,
  input  logic run,
  output logic expired
);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !run) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && !clr && (cnt_q == TIMER_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Drains the multi-pop UART RX FIFO and turns the byte stream into framed
// 16-bit samples for the FFT input path.
// Frame format: SYNC, LEN (samples, 1..255), 2*LEN payload bytes (little-endian
// samples), XOR checksum over LEN and all payload bytes.
//
// Parameters:
//   N           FIFO max pop width (must match uart_rx_module), N >= 2
//   SYNC        frame sync byte
//   TIMEOUT_CYC inter-byte timeout in clk cycles (timeout build only)
//   PW          derived pop/can_pop width, $clog2(N+1)
//
// Ports:
//   clk          in  system clock
//   arstn        in  asynchronous active-low reset
//   fifo_data    in  FIFO head bytes, [0] is oldest
//   fifo_can_pop in  bytes available in the FIFO
//   fifo_pop     out bytes popped this cycle (combinational, <= fifo_can_pop)
//   smp          master side of the sample stream (uart_rx_frame_ctrl_if)
//   frame_ok     out one-cycle pulse, checksum matched
//   frame_err    out one-cycle pulse, frame aborted or bad
//   err_code     out reason for the last frame_err (held until the next one)
//
// Build option: define UART_RX_FRAME_TIMEOUT_EN to abort frames that stall for
// TIMEOUT_CYC cycles without a byte (err_code 3). Without it a stalled frame
// waits indefinitely.
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl
  import uart_rx_frame_pkg::*;
#(
  parameter  int unsigned N           = 4,
  parameter  logic [7:0]  SYNC        = SYNC_DEFAULT,
  parameter  int unsigned TIMEOUT_CYC = 50000,
  localparam int unsigned PW          = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic [N-1:0][7:0]    fifo_data,
  input  logic [PW-1:0]        fifo_can_pop,
  output logic [PW-1:0]        fifo_pop,
  uart_rx_frame_ctrl_if.master smp,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [1:0]           err_code
);

  state_e      state_q,        state_d;
  logic [15:0] sample_q,       sample_d;
  logic        sample_valid_q, sample_valid_d;
  logic        sample_first_q, sample_first_d;
  logic        sample_last_q,  sample_last_d;
  logic        frame_ok_q,     frame_ok_d;
  logic        frame_err_q,    frame_err_d;
  err_code_e   err_code_q,     err_code_d;
  logic [7:0]  remaining_q,    remaining_d;
  logic [7:0]  chk_q,          chk_d;
  logic        first_pend_q,   first_pend_d;

  logic        pop_one;
  logic        pop_two;
  logic        tmo_expired;

  // Only the two oldest bytes are ever consumed in one cycle.
  if (N > 2) begin : g_unused_hi
    logic unused_fifo_hi;
    assign unused_fifo_hi = ^fifo_data[N-1:2];
  end

  // Pop request. Payload moves strictly in byte pairs, and only when the
  // output register is free or being drained this cycle.
  always_comb begin
    fifo_pop = '0;
    case (state_q)
      DATA: begin
        if ((fifo_can_pop >= PW'(2)) && (!sample_valid_q || smp.sample_ready)) begin
          fifo_pop = PW'(2);
        end
      end
      default: begin
        if (fifo_can_pop != '0) begin
          fifo_pop = PW'(1);
        end
      end
    endcase
  end

  assign pop_one = (fifo_pop == PW'(1));
  assign pop_two = (fifo_pop == PW'(2));

`ifdef UART_RX_FRAME_TIMEOUT_EN
  logic tmo_run;
  logic tmo_clr;

  assign tmo_run = (state_q != HUNT);
  assign tmo_clr = (fifo_pop != '0) || (state_q == HUNT);

  uart_rx_frame_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .arstn   (arstn),
    .clr     (tmo_clr),
    .run     (tmo_run),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;

  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d        = state_q;
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    sample_first_d = sample_first_q;
    sample_last_d  = sample_last_q;
    frame_ok_d     = 1'b0;
    frame_err_d    = 1'b0;
    err_code_d     = err_code_q;
    remaining_d    = remaining_q;
    chk_d          = chk_q;
    first_pend_d   = first_pend_q;

    // An accepted sample frees the output register; a load below overrides
    // this so accept-and-load streams one sample per clock.
    if (sample_valid_q && smp.sample_ready) begin
      sample_valid_d = 1'b0;
    end

    case (state_q)
      HUNT: begin
        if (pop_one && (fifo_data[0] == SYNC)) begin
          state_d = LEN;
        end
      end

      LEN: begin
        if (pop_one) begin
          chk_d        = fifo_data[0];
          remaining_d  = fifo_data[0];
          first_pend_d = 1'b1;
          if (fifo_data[0] == 8'd0) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = HUNT;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (pop_two) begin
          sample_d       = pack_sample(fifo_data[0], fifo_data[1]);
          sample_valid_d = 1'b1;
          sample_first_d = first_pend_q;
          sample_last_d  = (remaining_q == 8'd1);
          first_pend_d   = 1'b0;
          chk_d          = chk_q ^ fifo_data[0] ^ fifo_data[1];
          remaining_d    = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            state_d = CHK;
          end
        end
      end

      CHK: begin
        // The last sample may still be waiting downstream; it is left alone.
        if (pop_one) begin
          if (fifo_data[0] == chk_q) begin
            frame_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
          state_d = HUNT;
        end
      end
    endcase

    // Expiry implies no pop this cycle, so nothing above is overridden except
    // the state. A pending sample stays valid and sample_last is not forced.
    if (tmo_expired) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TMO;
      state_d     = HUNT;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q        <= HUNT;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      sample_first_q <= 1'b0;
      sample_last_q  <= 1'b0;
      frame_ok_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      err_code_q     <= ERR_NONE;
      remaining_q    <= '0;
      chk_q          <= '0;
      first_pend_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      sample_first_q <= sample_first_d;
      sample_last_q  <= sample_last_d;
      frame_ok_q     <= frame_ok_d;
      frame_err_q    <= frame_err_d;
      err_code_q     <= err_code_d;
      remaining_q    <= remaining_d;
      chk_q          <= chk_d;
      first_pend_q   <= first_pend_d;
    end
  end

  assign smp.sample       = sample_q;
  assign smp.sample_valid = sample_valid_q;
  assign smp.sample_first = sample_first_q;
  assign smp.sample_last  = sample_last_q;
  assign frame_ok         = frame_ok_q;
  assign frame_err        = frame_err_q;
  assign err_code         = err_code_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
// Scoreboard bench for uart_rx_frame_ctrl. Stimulus pushes bytes into a FIFO
// model and queues the expected samples / status pulses; a monitor on the
// falling edge pops and compares whenever the DUT presents a handshake or a
// status pulse. Checksums include the length byte.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

  localparam int N   = 4;
  localparam int PW  = $clog2(N + 1);
  localparam int TMO = 100;

  logic              clk = 1'b0;
  logic              arstn;
  logic [N-1:0][7:0] fifo_data;
  logic [PW-1:0]     fifo_can_pop;
  logic [PW-1:0]     fifo_pop;
  logic              frame_ok;
  logic              frame_err;
  logic [1:0]        err_code;

  uart_rx_frame_ctrl_if smp ();

  uart_rx_frame_ctrl #(
    .N           (N),
    .SYNC        (8'hA5),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .arstn        (arstn),
    .fifo_data    (fifo_data),
    .fifo_can_pop (fifo_can_pop),
    .fifo_pop     (fifo_pop),
    .smp          (smp),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: bytes written by stimulus, removed at the clock edge by pop.
  logic [7:0] mem [0:511];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int avail;

  always_comb begin
    avail = wr_ptr - rd_ptr;
    if (avail > N) avail = N;
    fifo_can_pop = PW'(avail);
    for (int i = 0; i < N; i++) begin
      fifo_data[i] = (i < avail) ? mem[rd_ptr + i] : 8'h00;
    end
  end

  always @(posedge clk) rd_ptr <= rd_ptr + int'(fifo_pop);

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Scoreboard
  int n_pass  = 0;
  int n_total = 0;
  int n_hs    = 0;
  int n_stat  = 0;
  logic [17:0] exp_smp[$];   // {first, last, sample}
  logic [3:0]  exp_st[$];    // {ok, err, code-if-err}
  logic [17:0] mon_es;
  logic [3:0]  mon_et;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got 0x%0h with no expected entry", name, act);
  endtask

  always @(negedge clk) begin
    if (arstn) begin
      if (smp.sample_valid && smp.sample_ready) begin
        n_hs++;
        if (exp_smp.size() == 0) begin
          fail_evt("unexpected_sample", {14'd0, smp.sample_first, smp.sample_last, smp.sample});
        end else begin
          mon_es = exp_smp.pop_front();
          check("sample", {14'd0, smp.sample_first, smp.sample_last, smp.sample}, {14'd0, mon_es});
        end
      end
      if (frame_ok || frame_err) begin
        n_stat++;
        check("ok_err_exclusive", {31'd0, frame_ok & frame_err}, 32'd0);
        if (exp_st.size() == 0) begin
          fail_evt("unexpected_status", {28'd0, frame_ok, frame_err, err_code});
        end else begin
          mon_et = exp_st.pop_front();
          check("status", {28'd0, frame_ok, frame_err, frame_err ? err_code : 2'b00},
                {28'd0, mon_et});
        end
      end
      if (fifo_pop != '0) begin
        check("pop_le_can_pop", {31'd0, fifo_pop <= fifo_can_pop}, 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_smp.size() != 0 || exp_st.size() != 0) && k < 600) begin
      tick(1);
      k++;
    end
    check({name, "_drained"}, exp_smp.size() + exp_st.size(), 0);
    tick(2);
  endtask

  task automatic good_abcd_frame(input string name);
    push(8'hA5); push(8'h01); push(8'hCD); push(8'hAB); push(8'h67);
    exp_smp.push_back({1'b1, 1'b1, 16'hABCD});
    exp_st.push_back(4'b1000);
    drain(name);
  endtask

  int base;
  int base_hs;
  int last_pop;
  int err_cyc;

  initial begin
    arstn = 1'b1;
    smp.sample_ready = 1'b1;
    #1 arstn = 1'b0;
    #1;
    // Reset state
    check("rst_valid",    {31'd0, smp.sample_valid}, 0);
    check("rst_first",    {31'd0, smp.sample_first}, 0);
    check("rst_last",     {31'd0, smp.sample_last},  0);
    check("rst_sample",   {16'd0, smp.sample},       0);
    check("rst_frame_ok", {31'd0, frame_ok},         0);
    check("rst_frame_err",{31'd0, frame_err},        0);
    check("rst_err_code", {30'd0, err_code},         0);
    check("rst_fifo_pop", {29'd0, fifo_pop},         0);
    tick(2);
    arstn = 1'b1;
    tick(2);

    // Garbage then a 2-sample frame
    push(8'h11); push(8'h22); push(8'hA5); push(8'h02);
    push(8'h34); push(8'h12); push(8'h78); push(8'h56); push(8'h0A);
    exp_smp.push_back({1'b1, 1'b0, 16'h1234});
    exp_smp.push_back({1'b0, 1'b1, 16'h5678});
    exp_st.push_back(4'b1000);
    drain("garbage_frame");
    check("garbage_fifo_empty", rd_ptr, wr_ptr);

    // Zero length, then a good single-sample frame
    push(8'hA5); push(8'h00);
    exp_st.push_back(4'b0101);
    drain("zero_len");
    good_abcd_frame("after_zero_len");
    check("err_code_hold_1", {30'd0, err_code}, 1);

    // Bad checksum
    push(8'hA5); push(8'h01); push(8'hCD); push(8'hAB); push(8'h00);
    exp_smp.push_back({1'b1, 1'b1, 16'hABCD});
    exp_st.push_back(4'b0110);
    drain("bad_chk");
    check("err_code_hold_2", {30'd0, err_code}, 2);

    // Backpressure: 4 samples, ready low for 10 cycles
    smp.sample_ready = 1'b0;
    base = rd_ptr;
    push(8'hA5); push(8'h04);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    push(8'h55); push(8'h66); push(8'h77); push(8'h88); push(8'h8C);
    exp_smp.push_back({1'b1, 1'b0, 16'h2211});
    exp_smp.push_back({1'b0, 1'b0, 16'h4433});
    exp_smp.push_back({1'b0, 1'b0, 16'h6655});
    exp_smp.push_back({1'b0, 1'b1, 16'h8877});
    exp_st.push_back(4'b1000);
    tick(10);
    check("bp_bytes_popped", rd_ptr - base, 4);
    check("bp_pop_zero",     {29'd0, fifo_pop},         0);
    check("bp_valid_held",   {31'd0, smp.sample_valid}, 1);
    check("bp_sample_held",  {16'd0, smp.sample},       32'h2211);
    check("bp_first_held",   {31'd0, smp.sample_first}, 1);
    base_hs = n_hs;
    smp.sample_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("bp_back_to_back", n_hs - base_hs, 4);
    drain("backpressure");

    // Trickle: a lone payload byte must not be popped
    base = rd_ptr;
    push(8'hA5); push(8'h02); push(8'h34);
    tick(6);
    check("trickle_bytes_popped", rd_ptr - base, 2);
    check("trickle_can_pop",      {29'd0, fifo_can_pop}, 1);
    check("trickle_pop_zero",     {29'd0, fifo_pop},     0);
    smp.sample_ready = 1'b0;
    push(8'h12);
    tick(3);
    check("trickle_valid",  {31'd0, smp.sample_valid}, 1);
    check("trickle_sample", {16'd0, smp.sample},       32'h1234);
    check("trickle_first",  {31'd0, smp.sample_first}, 1);
    check("trickle_last",   {31'd0, smp.sample_last},  0);
    push(8'h78);
    tick(3);
    check("trickle_pop_zero_2", {29'd0, fifo_pop}, 0);

    // Mid-frame reset: outputs clear at once, FIFO keeps its 0x78
    arstn = 1'b0;
    #1;
    check("mrst_valid",    {31'd0, smp.sample_valid}, 0);
    check("mrst_sample",   {16'd0, smp.sample},       0);
    check("mrst_first",    {31'd0, smp.sample_first}, 0);
    check("mrst_err_code", {30'd0, err_code},         0);
    tick(1);
    arstn = 1'b1;
    smp.sample_ready = 1'b1;
    tick(1);
    good_abcd_frame("after_mid_reset");
    check("mrst_fifo_empty", rd_ptr, wr_ptr);

`ifdef UART_RX_FRAME_TIMEOUT_EN
    // Stalled frame aborts TMO edges after the last pop
    push(8'hA5); push(8'h03); push(8'h12); push(8'h34);
    exp_smp.push_back({1'b1, 1'b0, 16'h3412});
    exp_st.push_back(4'b0111);
    last_pop = 0;
    err_cyc  = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (fifo_pop != '0) last_pop = cyc + 1;
      if (frame_err) begin
        err_cyc = cyc;
        break;
      end
    end
    check("tmo_latency", err_cyc - last_pop, TMO);
    drain("timeout");
    good_abcd_frame("after_timeout");
`else
    // Without the timeout a stalled frame just waits
    base = n_stat;
    push(8'hA5); push(8'h03); push(8'h12); push(8'h34);
    exp_smp.push_back({1'b1, 1'b0, 16'h3412});
    tick(150);
    check("no_timeout_pulse", n_stat - base, 0);
    drain("stalled");
    arstn = 1'b0;
    tick(1);
    arstn = 1'b1;
    tick(1);
    good_abcd_frame("after_stall_reset");
`endif

    check("final_samples_empty", exp_smp.size(), 0);
    check("final_status_empty",  exp_st.size(),  0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time %0t required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
